fc_layer_sequencer: RTL and testbench

Sequential controller wrapped around a bank of OUT_N combinational fully-connected neurons. Each neuron is a constant-weight multiplier / adder tree / ReLU instance. The controller:
- collects one input vector as a serial valid/ready stream into a holding buffer;
- drives the buffer onto the bank's shared x input and waits a settle interval;
- captures all neuron outputs and streams them out one per handshake;
- reports the argmax class index.
It sits between the previous layer's serial output and the next stage or classifier output.

---
 rtl/fc_layer_sequencer.sv | 138 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Controller around a bank of constant-weight FC neurons: loads one serial input frame,
// waits for the bank to settle, captures it, streams results out and reports the argmax.
module fc_layer_sequencer #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT_N  = 10,
  parameter int ACC_W  = 22,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic [IN*WIDTH-1:0]      x_vec,
  input  logic [OUT_N*ACC_W-1:0]   z_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [$clog2(OUT_N)-1:0] out_idx,
  output logic                     out_last,
  output logic                     class_valid,
  output logic [$clog2(OUT_N)-1:0] class_idx,
  output logic                     err_len,
  output logic                     busy
);
  localparam int CNT_W = $clog2(IN);
  localparam int IDX_W = $clog2(OUT_N);
  localparam int SW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_N - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_EMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    scnt;
  logic [IDX_W-1:0] e;
  logic [IDX_W-1:0] e_nxt;
  logic [WIDTH-1:0] xbuf [IN];
  logic [ACC_W-1:0] cap  [OUT_N];
  logic [ACC_W-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic             upd;

  always_comb begin
    x_vec = '0;
    for (int i = 0; i < IN; i++) x_vec[i*WIDTH +: WIDTH] = xbuf[i];
  end

  assign e_nxt = e + IDX_W'(1);
  // Argmax candidate: element 0 seeds the running max, later ones replace it only when strictly larger.
  assign upd   = (e == '0) || (out_data > max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      cnt         <= '0;
      scnt        <= '0;
      e           <= '0;
      for (int i = 0; i < IN; i++) xbuf[i] <= '0;
      for (int k = 0; k < OUT_N; k++) cap[k] <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      err_len     <= 1'b0;
      busy        <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
    end else begin
      class_valid <= 1'b0;
      err_len     <= 1'b0;
      case (state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            xbuf[cnt] <= in_data;
            // Unwritten tail elements are already zero: the buffer is cleared on every return to LOAD.
            if (in_last || cnt == CNT_LAST) begin
              err_len  <= !(in_last && cnt == CNT_LAST);
              state    <= ST_SETTLE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              cnt      <= '0;
              scnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (scnt == SW'(SETTLE)) begin
            for (int k = 0; k < OUT_N; k++) cap[k] <= z_vec[k*ACC_W +: ACC_W];
            e     <= '0;
            state <= ST_EMIT;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= cap[e];
            out_idx   <= e;
            out_last  <= (e == IDX_LAST);
          end else if (out_ready) begin
            if (upd) begin
              max_val <= out_data;
              max_idx <= e;
            end
            if (e == IDX_LAST) begin
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              class_valid <= 1'b1;
              class_idx   <= upd ? e : max_idx;
              e           <= '0;
              state       <= ST_LOAD;
              in_ready    <= 1'b1;
              busy        <= 1'b0;
              for (int i = 0; i < IN; i++) xbuf[i] <= '0;
            end else begin
              e        <= e_nxt;
              out_data <= cap[e_nxt];
              out_idx  <= e_nxt;
              out_last <= (e_nxt == IDX_LAST);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: stub neuron bank driven from z_vec, expected
// outputs queued when a frame is prepared and popped as the DUT emits them.
module tb_fc_layer_sequencer;
  localparam int WIDTH = 8, IN = 128, OUT_N = 10, ACC_W = 22, SETTLE = 2, IW = 4;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last, class_valid, err_len, busy;
  logic [WIDTH-1:0]       in_data = '0;
  logic [IN*WIDTH-1:0]    x_vec;
  logic [OUT_N*ACC_W-1:0] z_vec = '0;
  logic [ACC_W-1:0]       out_data;
  logic [IW-1:0]          out_idx, class_idx;

  int total = 0, bad = 0, cyc = 0, err_cnt = 0, cls_cnt = 0;
  logic [IW-1:0] cls_seen = '0;
  int last_cyc, first_v, stable_err, rdy_err, xv_err, exp_cls;
  logic [WIDTH-1:0]    exp_x [IN];
  logic [IN*WIDTH-1:0] exp_xv;
  logic [ACC_W-1:0]    exp_q [$];
  logic [ACC_W-1:0]    obs_d [$];
  logic [IW-1:0]       obs_i [$];
  logic                obs_l [$];

  fc_layer_sequencer #(.WIDTH(WIDTH), .IN(IN), .OUT_N(OUT_N), .ACC_W(ACC_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .x_vec(x_vec), .z_vec(z_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .class_valid(class_valid),
    .class_idx(class_idx), .err_len(err_len), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (err_len) err_cnt <= err_cnt + 1;
    if (class_valid) begin
      cls_cnt  <= cls_cnt + 1;
      cls_seen <= class_idx;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // mode 0: z[k]=100*k, mode 1: tie pattern, mode 2: random
  task automatic prep(input int mode);
    int unsigned tv [OUT_N];
    int best;
    for (int k = 0; k < OUT_N; k++)
      tv[k] = (mode == 0) ? 100 * k : $urandom_range(0, (1 << ACC_W) - 1);
    if (mode == 1) tv = '{5, 7, 7, 3, 7, 0, 0, 0, 0, 0};
    exp_q.delete();
    best = 0;
    for (int k = 0; k < OUT_N; k++) begin
      z_vec[k*ACC_W +: ACC_W] = ACC_W'(tv[k]);
      exp_q.push_back(ACC_W'(tv[k]));
      if (k > 0 && tv[k] > tv[best]) best = k;
    end
    exp_cls = best;
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_max);
    int g, w;
    for (int i = 0; i < IN; i++) exp_x[i] = '0;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin @(posedge clk); @(negedge clk); end
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); @(negedge clk); w++; end
      total++;
      if (in_ready !== 1'b1) begin
        $display("FAIL in_ready_wait beat=%0d got=%b want=1", i, in_ready);
        bad++;
        break;
      end
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      in_last  = (i == last_at);
      exp_x[i] = in_data;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    last_cyc = cyc;
    for (int i = 0; i < IN; i++) exp_xv[i*WIDTH +: WIDTH] = exp_x[i];
  endtask

  // mode 0: always ready; mode 1: ready 1,0,0,1 over valid cycles
  task automatic collect(input int mode, input int max_hs, input bit drive_in);
    logic held_v;
    logic [ACC_W-1:0] held_d;
    logic [IW-1:0] held_i;
    int hs, vc;
    obs_d.delete(); obs_i.delete(); obs_l.delete();
    stable_err = 0; rdy_err = 0; xv_err = 0; first_v = -1; hs = 0; vc = 0; held_v = 1'b0;
    held_d = '0; held_i = '0;
    in_valid = drive_in; in_data = 8'h5A; in_last = 1'b0;
    for (int c = 0; c < 300 && hs < max_hs; c++) begin
      if (held_v && (out_valid !== 1'b1 || out_data !== held_d || out_idx !== held_i)) stable_err++;
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
      if (x_vec !== exp_xv) xv_err++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (mode == 0 || !out_valid) out_ready = 1'b1;
      else begin
        out_ready = (vc % 4 == 0) || (vc % 4 == 3);
        vc++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_idx;
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data); obs_i.push_back(out_idx); obs_l.push_back(out_last);
        hs++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (hs < max_hs) begin
      $display("FAIL collect_timeout got=%0d want=%0d", hs, max_hs);
      bad++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, class_valid, err_len, out_last} !== 6'b0 ||
        out_data !== '0 || out_idx !== '0 || class_idx !== '0 || x_vec !== '0) begin
      $display("FAIL reset_outputs got=%b%b%b%b%b%b want=000000", in_ready, out_valid, busy,
               class_valid, err_len, out_last);
      bad++;
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin $display("FAIL reset_release_ready got=%b want=0", in_ready); bad++; end
    @(posedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_ready_rise got=%b want=1", in_ready); bad++; end
  endtask

  task automatic test_nominal();
    int e0, c0;
    logic [ACC_W-1:0] d;
    e0 = err_cnt; c0 = cls_cnt;
    prep(0);
    send_frame(IN, IN - 1, 0);
    total++;
    if (x_vec !== exp_xv) begin $display("FAIL nominal_xvec got=%h want=%h", x_vec[63:0], exp_xv[63:0]); bad++; end
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL nominal_settle_busy got=%b%b want=10", busy, in_ready); bad++;
    end
    collect(0, OUT_N, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin $display("FAIL nominal_valid_fall got=%b want=0", out_valid); bad++; end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (first_v !== last_cyc + SETTLE + 2) begin
      $display("FAIL nominal_latency got=%0d want=%0d", first_v - last_cyc, SETTLE + 2); bad++;
    end
    total++;
    if (obs_d.size() != OUT_N) begin $display("FAIL nominal_count got=%0d want=%0d", obs_d.size(), OUT_N); bad++; end
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k) || obs_l[k] !== (k == OUT_N - 1)) begin
        $display("FAIL nominal_out k=%0d got=%0d/%0d/%b want=%0d/%0d/%b", k, obs_d[k], obs_i[k], obs_l[k],
                 d, k, k == OUT_N - 1);
        bad++;
      end
    end
    total++;
    if (cls_cnt - c0 != 1 || cls_seen !== IW'(exp_cls)) begin
      $display("FAIL nominal_class got=%0d/%0d want=1/%0d", cls_cnt - c0, cls_seen, exp_cls); bad++;
    end
    total++;
    if (err_cnt != e0 || rdy_err != 0 || xv_err != 0) begin
      $display("FAIL nominal_side got=%0d/%0d/%0d want=0/0/0", err_cnt - e0, rdy_err, xv_err); bad++;
    end
  endtask

  task automatic test_backpressure();
    int c0;
    logic [ACC_W-1:0] d;
    c0 = cls_cnt;
    prep(2);
    send_frame(IN, IN - 1, 0);
    collect(1, OUT_N, 1'b0);
    #1;
    total++;
    if (stable_err != 0) begin $display("FAIL bp_stable got=%0d want=0", stable_err); bad++; end
    total++;
    if (obs_d.size() != OUT_N) begin $display("FAIL bp_count got=%0d want=%0d", obs_d.size(), OUT_N); bad++; end
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k)) begin
        $display("FAIL bp_out k=%0d got=%0d/%0d want=%0d/%0d", k, obs_d[k], obs_i[k], d, k); bad++;
      end
    end
    total++;
    if (cls_cnt - c0 != 1 || cls_seen !== IW'(exp_cls)) begin
      $display("FAIL bp_class got=%0d/%0d want=1/%0d", cls_cnt - c0, cls_seen, exp_cls); bad++;
    end
  endtask

  task automatic test_input_stall();
    logic [ACC_W-1:0] d;
    prep(2);
    send_frame(IN, IN - 1, 3);
    total++;
    if (x_vec !== exp_xv) begin $display("FAIL stall_xvec got=%h want=%h", x_vec[63:0], exp_xv[63:0]); bad++; end
    collect(0, OUT_N, 1'b1);
    #1;
    total++;
    if (rdy_err != 0 || xv_err != 0) begin
      $display("FAIL stall_no_accept got=%0d/%0d want=0/0", rdy_err, xv_err); bad++;
    end
    total++;
    if (x_vec !== '0) begin $display("FAIL stall_buf_clear got=%h want=0", x_vec[63:0]); bad++; end
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k)) begin
        $display("FAIL stall_out k=%0d got=%0d/%0d want=%0d/%0d", k, obs_d[k], obs_i[k], d, k); bad++;
      end
    end
  endtask

  task automatic test_early_last();
    int e0;
    logic [ACC_W-1:0] d;
    e0 = err_cnt;
    prep(0);
    send_frame(64, 63, 0);
    #1;
    total++;
    if (err_cnt - e0 != 1) begin $display("FAIL early_err got=%0d want=1", err_cnt - e0); bad++; end
    total++;
    if (x_vec[IN*WIDTH-1:64*WIDTH] !== '0) begin
      $display("FAIL early_tail_zero got=%h want=0", x_vec[IN*WIDTH-1 -: 64]); bad++;
    end
    total++;
    if (x_vec !== exp_xv) begin $display("FAIL early_xvec got=%h want=%h", x_vec[63:0], exp_xv[63:0]); bad++; end
    collect(0, OUT_N, 1'b0);
    #1;
    total++;
    if (err_cnt - e0 != 1 || xv_err != 0) begin
      $display("FAIL early_err_once got=%0d/%0d want=1/0", err_cnt - e0, xv_err); bad++;
    end
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k)) begin
        $display("FAIL early_out k=%0d got=%0d/%0d want=%0d/%0d", k, obs_d[k], obs_i[k], d, k); bad++;
      end
    end
  endtask

  task automatic test_ties_missing_last();
    int e0, c0;
    e0 = err_cnt; c0 = cls_cnt;
    prep(1);
    send_frame(IN, -1, 0);
    #1;
    total++;
    if (err_cnt - e0 != 1) begin $display("FAIL nolast_err got=%0d want=1", err_cnt - e0); bad++; end
    collect(0, OUT_N, 1'b0);
    #1;
    total++;
    if (obs_d.size() != OUT_N || obs_d[1] !== exp_q[1]) begin
      $display("FAIL ties_out got=%0d want=%0d", obs_d.size(), OUT_N); bad++;
    end
    exp_q.delete();
    total++;
    if (cls_cnt - c0 != 1 || cls_seen !== IW'(exp_cls)) begin
      $display("FAIL ties_class got=%0d/%0d want=1/%0d", cls_cnt - c0, cls_seen, exp_cls); bad++;
    end
  endtask

  task automatic test_reset_mid_emit();
    int e0, c0;
    logic [ACC_W-1:0] d;
    prep(0);
    send_frame(IN, IN - 1, 0);
    collect(0, 5, 1'b0);
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k)) begin
        $display("FAIL mid_pre_out k=%0d got=%0d/%0d want=%0d/%0d", k, obs_d[k], obs_i[k], d, k); bad++;
      end
    end
    exp_q.delete();
    #1;
    e0 = err_cnt; c0 = cls_cnt;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || x_vec !== '0) begin
      $display("FAIL mid_reset_async got=%b%b%b want=000", out_valid, busy, in_ready); bad++;
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin $display("FAIL mid_release_ready got=%b want=0", in_ready); bad++; end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || cls_cnt != c0 || err_cnt != e0) begin
      $display("FAIL mid_after_reset got=%b/%0d/%0d want=1/0/0", in_ready, cls_cnt - c0, err_cnt - e0); bad++;
    end
    prep(2);
    send_frame(IN, IN - 1, 0);
    collect(0, OUT_N, 1'b0);
    #1;
    total++;
    if (obs_d.size() != OUT_N) begin $display("FAIL mid_clean_count got=%0d want=%0d", obs_d.size(), OUT_N); bad++; end
    for (int k = 0; k < obs_d.size() && exp_q.size() > 0; k++) begin
      d = exp_q.pop_front();
      total++;
      if (obs_d[k] !== d || obs_i[k] !== IW'(k) || obs_l[k] !== (k == OUT_N - 1)) begin
        $display("FAIL mid_clean_out k=%0d got=%0d/%0d want=%0d/%0d", k, obs_d[k], obs_i[k], d, k); bad++;
      end
    end
    total++;
    if (cls_cnt - c0 != 1 || cls_seen !== IW'(exp_cls)) begin
      $display("FAIL mid_clean_class got=%0d/%0d want=1/%0d", cls_cnt - c0, cls_seen, exp_cls); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_input_stall();
    test_early_last();
    test_ties_missing_last();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
